// File: rtl/apb_timer_slave_if.sv
// rtl/apb_timer_slave_if.sv - APB bus bundle between the bridge master and the timer completer
//
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB  (master -> slave)
//          PRDATA, PREADY, PSLVERR                      (slave -> master)
interface apb_timer_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [3:0]            PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_slave.sv
// rtl/apb_timer_slave.sv - APB completer with a 32-bit auto-reload down-counter and level interrupt
//
// Ports: PCLK     clock
//        PRESETn  asynchronous active-low reset
//        apb      APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in,
//                 PRDATA/PREADY/PSLVERR out, all outputs registered)
//        irq      STATUS.expired & CTRL.irq_en
// Registers (PADDR[7:0]): 0x00 CTRL {irq_en,auto_reload,enable}, 0x04 LOAD,
//                         0x08 COUNT (RO), 0x0C STATUS {expired} W1C
module apb_timer_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_timer_slave_if.slave     apb,
    output logic                 irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t                state_q, state_d, phase;
    logic [3:0]            wait_q, wait_d;
    logic [1:0]            idx_q, idx_cur;
    logic                  err_q, err_cur, write_q, write_cur;
    logic                  pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rd_mux;
    logic                  finish, commit;

    logic                  ctrl_en, ctrl_auto, ctrl_irq_en, expired_q;
    logic [31:0]           load_q, count_q, load_wr_val;
    logic                  wr_ctrl, wr_load, wr_stat;

    logic [7:0]            off;
    logic                  setup_err;
    logic                  unused_addr;

    assign off         = apb.PADDR[7:0];
    assign unused_addr = ^apb.PADDR[ADDR_WIDTH-1:8];
    assign setup_err   = (off[1:0] != 2'b00) || (off > 8'h0C) || (apb.PWRITE && off == 8'h08);

    // The SETUP cycle is recognised combinationally (PSEL && !PENABLE while not in
    // ACCESS) so the registered PREADY can already be high in the first ACCESS cycle.
    always_comb begin
        phase     = IDLE;
        state_d   = IDLE;
        wait_d    = wait_q;
        finish    = 1'b0;
        commit    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (state_q == ACCESS)
            phase = ACCESS;
        else if (apb.PSEL && !apb.PENABLE)
            phase = SETUP;

        idx_cur   = (phase == SETUP) ? off[3:2]    : idx_q;
        err_cur   = (phase == SETUP) ? setup_err   : err_q;
        write_cur = (phase == SETUP) ? apb.PWRITE  : write_q;

        case (phase)
            SETUP: begin
                state_d = ACCESS;
                wait_d  = 4'(WAIT_STATES);
                finish  = (WAIT_STATES == 0);
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;                 // abandoned transfer, no side effects
                end else if (pready_q) begin
                    commit  = apb.PENABLE && write_q && !err_q;
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    if (wait_q != 4'd0)
                        wait_d = wait_q - 4'd1;
                    finish = (wait_q <= 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (idx_cur)
            2'd0:    rd_mux = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            2'd1:    rd_mux = load_q;
            2'd2:    rd_mux = count_q;
            default: rd_mux = {31'd0, expired_q};
        endcase

        if (finish) begin
            pready_d  = 1'b1;
            pslverr_d = err_cur;
            prdata_d  = (write_cur || err_cur) ? '0 : rd_mux;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            idx_q     <= 2'd0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (phase == SETUP) begin
                idx_q   <= off[3:2];
                err_q   <= setup_err;
                write_q <= apb.PWRITE;
            end
        end
    end

    assign wr_ctrl = commit && idx_q == 2'd0 && apb.PSTRB[0];
    assign wr_load = commit && idx_q == 2'd1;
    assign wr_stat = commit && idx_q == 2'd3 && apb.PSTRB[0] && apb.PWDATA[0];

    always_comb begin
        load_wr_val = load_q;
        for (int i = 0; i < 4; i++)
            if (apb.PSTRB[i])
                load_wr_val[8*i +: 8] = apb.PWDATA[8*i +: 8];
    end

    // Assignment order sets the collision priorities: expiry beats the W1C,
    // bus writes to CTRL/LOAD beat the counter's own update.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load_q      <= 32'd0;
            count_q     <= 32'd0;
            expired_q   <= 1'b0;
        end else begin
            if (wr_stat)
                expired_q <= 1'b0;
            if (ctrl_en) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else begin
                    expired_q <= 1'b1;
                    if (ctrl_auto)
                        count_q <= load_q;
                    else
                        ctrl_en <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                ctrl_en     <= apb.PWDATA[0];
                ctrl_auto   <= apb.PWDATA[1];
                ctrl_irq_en <= apb.PWDATA[2];
            end
            if (wr_load) begin
                load_q  <= load_wr_val;
                count_q <= load_wr_val;
            end
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign irq         = expired_q & ctrl_irq_en;
endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB completer (slave) holding a 32-bit down-counting timer with auto-reload and an interrupt output.
- Sits on the PSEL_TIMER select line of the AXI4-to-APB bridge's APB master and answers its SETUP/ACCESS transfers.
- Supports a configurable number of wait states, byte strobes and PSLVERR for illegal accesses.

Parameters:
- ADDR_WIDTH, 32, width of PADDR.
- DATA_WIDTH, 32, width of PWDATA/PRDATA (fixed at 32 for this register map).
- WAIT_STATES, 0, number of cycles PREADY is held low in the ACCESS phase (0..15).

Ports:
- PCLK  input  1  clock
- PRESETn  input  1  asynchronous active-low reset
- PSEL  input  1  slave select (driven from master's PSEL_TIMER)
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_WIDTH  byte address; only PADDR[7:0] decoded
- PWDATA  input  DATA_WIDTH  write data
- PSTRB  input  4  write byte-lane strobes
- PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1
- PREADY  output  1  transfer completion
- PSLVERR  output  1  error response, valid only while PREADY=1
- irq  output  1  level interrupt = STATUS.expired & CTRL.irq_en

Behaviour:
- Reset: asynchronous on PRESETn low; clock is PCLK.
  - All registers cleared and bus FSM in IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0, irq=0.
  - Reset asserted mid-transfer aborts the transfer; no register is written.
- Register map (offset, PADDR[7:0]):
  - 0x00 CTRL (RW): bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 LOAD (RW, 32b).
  - 0x08 COUNT (RO).
  - 0x0C STATUS: bit0 expired; write-1-to-clear via lane 0.
- Bus FSM states:
  - IDLE: go to SETUP when PSEL=1 && PENABLE=0.
  - SETUP: load wait counter with WAIT_STATES, latch address, decode and error flag; go to ACCESS.
  - ACCESS: decrement the wait counter while it is nonzero. PREADY=1 when PSEL && PENABLE && wait counter==0.
  - On the completing cycle, go to SETUP if PSEL && !PENABLE, else IDLE.
  - If PSEL drops in ACCESS before PREADY, return to IDLE with no side effects.
- Outputs and timing:
  - PREADY, PRDATA and PSLVERR are registered.
  - With WAIT_STATES=0, PREADY is high in the first ACCESS cycle (2-cycle transfer). Each wait state adds one cycle.
  - PRDATA=0 whenever PREADY=0 or the transfer is a write.
- Error (PSLVERR=1 with PREADY) for any of:
  - PADDR[1:0]!=0;
  - offset > 0x0C;
  - write to COUNT.
  - An erroring write modifies nothing. An erroring read returns PRDATA=0.
- Writes commit on the PREADY=1 cycle, per byte lane where PSTRB[i]=1.
  - Writing PSTRB=0000 is a legal no-op.
  - A write to LOAD also copies the resulting LOAD value into COUNT on the same edge.
- Counter (runs every PCLK while CTRL.enable=1):
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: STATUS.expired set.
    - auto_reload=1: COUNT <= LOAD.
    - auto_reload=0: CTRL.enable cleared and COUNT stays 0.
  - LOAD=0 with auto_reload=1: expires every cycle.
- Simultaneous events:
  - Expiry and a STATUS W1C in the same cycle: set wins, expired stays 1.
  - LOAD write and counter decrement in the same cycle: the LOAD write wins.
  - CTRL write clearing enable on the expiry cycle: expired still sets.
- irq: combinational from registered STATUS and CTRL; no glitch source.

Test Plan:
- Reset: pulse PRESETn low asynchronously mid-ACCESS with WAIT_STATES=3 -> PREADY=0, PSLVERR=0, PRDATA=0, CTRL/LOAD/COUNT/STATUS=0 immediately; no write committed.
- Zero-wait write/read: write LOAD=0x0000_0010 with PSTRB=1111, then read 0x08 -> PREADY high on first ACCESS cycle, PRDATA=0x0000_0010, PSLVERR=0.
- Byte strobes: LOAD=0x11223344, then write 0xAABBCCDD with PSTRB=0101 -> read LOAD = 0x11BB33DD.
- One-shot expiry: LOAD=3, CTRL=0x5 -> COUNT 3,2,1,0 over 3 cycles; expired=1, irq=1 and enable=0 on the next edge.
  - Then W1C STATUS=0x1 -> irq=0.
- Auto-reload with collision: LOAD=2, CTRL=0x7, and issue the STATUS W1C on the expiry cycle -> expired stays 1 and COUNT reloads to 2.
- Errors with WAIT_STATES=2: write to 0x08, read 0x10, access 0x02 -> PREADY exactly 2 cycles after ACCESS entry with PSLVERR=1; PRDATA=0; registers unchanged.
